// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared opcode encodings, FSM state type and opcode-class helpers for the
// pipeline hazard controller and its load-use comparator.
package hazard_pkg;

  localparam logic [4:0] OPC_LOAD_R = 5'b01010;
  localparam logic [4:0] OPC_LOAD_I = 5'b01011;
  localparam logic [4:0] OPC_JMP    = 5'b10011;
  localparam logic [4:0] OPC_BNE    = 5'b10100;
  localparam logic [4:0] OPC_BEQ    = 5'b10101;
  localparam logic [4:0] OPC_MULT   = 5'b10110;
  localparam logic [4:0] OPC_NOP    = 5'b10111;

  // Multiplier wait counter; wide enough for MULT_LAT up to 15.
  localparam int MCNT_W = 4;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LD_STALL  = 2'd1,
    ST_BR_WAIT   = 2'd2,
    ST_MULT_WAIT = 2'd3
  } state_e;

  function automatic logic uses_rb(input logic [4:0] opc);
    case (opc)
      5'b00000, 5'b00010, 5'b00100, 5'b00110, 5'b00111,
      5'b01001, 5'b10110, 5'b10000, 5'b10100, 5'b10101: uses_rb = 1'b1;
      default:                                         uses_rb = 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input logic [4:0] opc);
    is_load = (opc == OPC_LOAD_R) || (opc == OPC_LOAD_I);
  endfunction

  function automatic logic is_cbr(input logic [4:0] opc);
    is_cbr = (opc == OPC_BNE) || (opc == OPC_BEQ);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: stage opcodes/addresses in,
// stage enables/flush/bubble controls out. master = controller, slave = pipeline.
interface pipeline_hazard_ctrl_if #(
  parameter int OPC_W  = 5,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [OPC_W-1:0]  opc_ifid;
  logic [REG_AW-1:0] ra_ifid;
  logic [REG_AW-1:0] rb_ifid;
  logic [OPC_W-1:0]  opc_idex;
  logic [REG_AW-1:0] rd_idex;
  logic              wreg_idex;
  logic              branch_taken;
  logic              pc_we;
  logic              ifid_we;
  logic              ifid_flush;
  logic              idex_we;
  logic              idex_bubble;
  logic              pc_sel_branch;
  logic              mult_start;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    input  opc_ifid, ra_ifid, rb_ifid, opc_idex, rd_idex, wreg_idex, branch_taken,
    output pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, pc_sel_branch,
           mult_start, stall_cnt
  );

  modport slave (
    output opc_ifid, ra_ifid, rb_ifid, opc_idex, rd_idex, wreg_idex, branch_taken,
    input  pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, pc_sel_branch,
           mult_start, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_ld_detect.sv
// Combinational load-use comparator: flags an ID-stage read of the register a
// load in EX is about to write. Kept standalone so forwarding logic can reuse it.
module hazard_ld_detect
  import hazard_pkg::*;
#(
  parameter int OPC_W  = 5,
  parameter int REG_AW = 5
) (
  input  logic [OPC_W-1:0]  opc_idex_i,
  input  logic              wreg_idex_i,
  input  logic [REG_AW-1:0] rd_idex_i,
  input  logic [OPC_W-1:0]  opc_ifid_i,
  input  logic [REG_AW-1:0] ra_ifid_i,
  input  logic [REG_AW-1:0] rb_ifid_i,
  output logic              hazard_o
);
  logic ra_hit_s;
  logic rb_hit_s;

  // r0 is an ordinary register here, so no zero-address exclusion.
  assign ra_hit_s = (rd_idex_i == ra_ifid_i);
  assign rb_hit_s = (rd_idex_i == rb_ifid_i) && uses_rb(opc_ifid_i);
  assign hazard_o = is_load(opc_idex_i) && wreg_idex_i && (ra_hit_s || rb_hit_s);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch resolution and
// multiplier waits. Optional stall counter enabled by HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int OPC_W    = 5,
  parameter int REG_AW   = 5,
  parameter int MULT_LAT = 4,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.master hz
);
  localparam logic [MCNT_W-1:0] MCNT_INIT = MCNT_W'(MULT_LAT - 2);

  state_e              state_q, state_d;
  logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
  logic                ld_haz_s;
  logic                pc_we_s, ifid_we_s, idex_we_s;
  logic                ifid_flush_s, idex_bubble_s, pc_sel_s, mult_start_s;

  hazard_ld_detect #(.OPC_W(OPC_W), .REG_AW(REG_AW)) u_ld_detect (
    .opc_idex_i  (hz.opc_idex),
    .wreg_idex_i (hz.wreg_idex),
    .rd_idex_i   (hz.rd_idex),
    .opc_ifid_i  (hz.opc_ifid),
    .ra_ifid_i   (hz.ra_ifid),
    .rb_ifid_i   (hz.rb_ifid),
    .hazard_o    (ld_haz_s)
  );

  // State and multiplier-wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
    end
  end

  // Next-state selection; RUN checks are in strict priority order.
  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    case (state_q)
      ST_RUN: begin
        if (hz.opc_idex == OPC_MULT) begin
          state_d = ST_MULT_WAIT;
          mcnt_d  = MCNT_INIT;
        end else if (is_cbr(hz.opc_idex)) begin
          state_d = ST_RUN;
        end else if (is_cbr(hz.opc_ifid)) begin
          state_d = ST_BR_WAIT;
        end else if (hz.opc_ifid == OPC_JMP) begin
          state_d = ST_RUN;
        end else if (ld_haz_s) begin
          state_d = ST_LD_STALL;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LD_STALL: state_d = ST_RUN;
      ST_BR_WAIT:  state_d = ST_RUN;
      ST_MULT_WAIT: begin
        if (mcnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          mcnt_d = mcnt_q - MCNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Stage controls; held at their reset values while rst_n is low so a mult
  // sitting in ID/EX cannot raise mult_start during reset.
  always_comb begin
    pc_we_s       = 1'b1;
    ifid_we_s     = 1'b1;
    idex_we_s     = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_bubble_s = 1'b0;
    pc_sel_s      = 1'b0;
    mult_start_s  = 1'b0;
    if (!rst_n) begin
      pc_we_s = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hz.opc_idex == OPC_MULT) begin
            mult_start_s = 1'b1;
            pc_we_s      = 1'b0;
            ifid_we_s    = 1'b0;
            idex_we_s    = 1'b0;
          end else if (is_cbr(hz.opc_idex)) begin
            if (hz.branch_taken) begin
              pc_sel_s      = 1'b1;
              ifid_flush_s  = 1'b1;
              idex_bubble_s = 1'b1;
            end else begin
              pc_sel_s = 1'b0;
            end
          end else if (is_cbr(hz.opc_ifid)) begin
            pc_we_s   = 1'b0;
            ifid_we_s = 1'b0;
          end else if (hz.opc_ifid == OPC_JMP) begin
            pc_sel_s     = 1'b1;
            ifid_flush_s = 1'b1;
          end else if (ld_haz_s) begin
            pc_we_s       = 1'b0;
            ifid_we_s     = 1'b0;
            idex_bubble_s = 1'b1;
          end else begin
            pc_we_s = 1'b1;
          end
        end
        ST_LD_STALL: pc_we_s = 1'b1;
        ST_BR_WAIT: begin
          pc_we_s   = 1'b0;
          ifid_we_s = 1'b0;
        end
        ST_MULT_WAIT: begin
          pc_we_s   = (mcnt_q == '0);
          ifid_we_s = pc_we_s;
          idex_we_s = pc_we_s;
        end
        default: pc_we_s = 1'b1;
      endcase
    end
  end

  assign hz.pc_we         = pc_we_s;
  assign hz.ifid_we       = ifid_we_s;
  assign hz.idex_we       = idex_we_s;
  assign hz.ifid_flush    = ifid_flush_s;
  assign hz.idex_bubble   = idex_bubble_s;
  assign hz.pc_sel_branch = pc_sel_s;
  assign hz.mult_start    = mult_start_s;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (!pc_we_s && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
`else
  assign hz.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MULT_LAT=4).
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, pc_sel_branch, mult_start}
  localparam logic [6:0] O_IDLE  = 7'b1101000;
  localparam logic [6:0] O_LDST  = 7'b0001100;
  localparam logic [6:0] O_BRW   = 7'b0001000;
  localparam logic [6:0] O_TAKEN = 7'b1111110;
  localparam logic [6:0] O_JMP   = 7'b1111010;
  localparam logic [6:0] O_MST   = 7'b0000001;
  localparam logic [6:0] O_MW    = 7'b0000000;

  pipeline_hazard_ctrl_if #(.OPC_W(5), .REG_AW(5), .CNT_W(16)) hz_if ();

  pipeline_hazard_ctrl #(.OPC_W(5), .REG_AW(5), .MULT_LAT(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz_if)
  );

  function automatic logic [6:0] outs();
    return {hz_if.pc_we, hz_if.ifid_we, hz_if.ifid_flush, hz_if.idex_we,
            hz_if.idex_bubble, hz_if.pc_sel_branch, hz_if.mult_start};
  endfunction

  task automatic drive(input logic [4:0] oi, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [4:0] oe, input logic [4:0] rd, input logic w,
                       input logic bt);
    hz_if.opc_ifid     = oi;
    hz_if.ra_ifid      = ra;
    hz_if.rb_ifid      = rb;
    hz_if.opc_idex     = oe;
    hz_if.rd_idex      = rd;
    hz_if.wreg_idex    = w;
    hz_if.branch_taken = bt;
  endtask

  task automatic drive_nop();
    drive(OPC_NOP, 5'd0, 5'd0, OPC_NOP, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_nop();
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_nop();
    #2;
    checks++;
    if (outs() !== O_IDLE) begin
      errors++; $display("FAIL reset_outs got %b exp %b", outs(), O_IDLE);
    end
    checks++;
    if (hz_if.stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_stall_cnt got %0d exp 0", hz_if.stall_cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (outs() !== O_IDLE) begin
      errors++; $display("FAIL reset_release got %b exp %b", outs(), O_IDLE);
    end
  endtask

  task automatic test_load_use();
    drive(5'b00000, 5'd3, 5'd0, OPC_LOAD_R, 5'd3, 1'b1, 1'b0);
    #1;
    checks++;
    if (outs() !== O_LDST) begin
      errors++; $display("FAIL ld_use_ra got %b exp %b", outs(), O_LDST);
    end
    tick();
    checks++;
    if (outs() !== O_IDLE) begin
      errors++; $display("FAIL ld_stall_one_cycle got %b exp %b", outs(), O_IDLE);
    end
    tick();
    drive_nop();
    #1;
    checks++;
    if (outs() !== O_IDLE) begin
      errors++; $display("FAIL ld_back_to_run got %b exp %b", outs(), O_IDLE);
    end
    drive(5'b00000, 5'd7, 5'd3, OPC_LOAD_I, 5'd3, 1'b1, 1'b0);
    #1;
    checks++;
    if (outs() !== O_LDST) begin
      errors++; $display("FAIL ld_use_rb got %b exp %b", outs(), O_LDST);
    end
    tick();
    drive_nop();
    tick();
    drive(5'b00000, 5'd3, 5'd0, OPC_LOAD_R, 5'd3, 1'b0, 1'b0);
    #1;
    checks++;
    if (outs() !== O_IDLE) begin
      errors++; $display("FAIL ld_no_wreg got %b exp %b", outs(), O_IDLE);
    end
    drive(5'b00000, 5'd0, 5'd5, OPC_LOAD_R, 5'd0, 1'b1, 1'b0);
    #1;
    checks++;
    if (outs() !== O_LDST) begin
      errors++; $display("FAIL ld_use_r0 got %b exp %b", outs(), O_LDST);
    end
    tick();
    drive_nop();
    tick();
  endtask

  task automatic test_no_rb_user();
    drive(5'b01111, 5'd7, 5'd3, OPC_LOAD_R, 5'd3, 1'b1, 1'b0);
    #1;
    checks++;
    if (outs() !== O_IDLE) begin
      errors++; $display("FAIL movi_rb_no_stall got %b exp %b", outs(), O_IDLE);
    end
    drive_nop();
  endtask

  task automatic test_branch();
    drive(OPC_BEQ, 5'd1, 5'd2, OPC_NOP, 5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (outs() !== O_BRW) begin
      errors++; $display("FAIL beq_in_id got %b exp %b", outs(), O_BRW);
    end
    tick();
    drive(OPC_BEQ, 5'd1, 5'd2, OPC_BEQ, 5'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if (outs() !== O_BRW) begin
      errors++; $display("FAIL br_wait got %b exp %b", outs(), O_BRW);
    end
    tick();
    checks++;
    if (outs() !== O_TAKEN) begin
      errors++; $display("FAIL beq_taken got %b exp %b", outs(), O_TAKEN);
    end
    tick();
    drive_nop();
    drive(OPC_BNE, 5'd1, 5'd2, OPC_NOP, 5'd0, 1'b0, 1'b0);
    #1;
    tick();
    drive(OPC_BNE, 5'd1, 5'd2, OPC_BNE, 5'd0, 1'b0, 1'b0);
    tick();
    checks++;
    if (outs() !== O_IDLE) begin
      errors++; $display("FAIL bne_not_taken got %b exp %b", outs(), O_IDLE);
    end
    tick();
    drive(OPC_JMP, 5'd0, 5'd0, OPC_NOP, 5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (outs() !== O_JMP) begin
      errors++; $display("FAIL jump got %b exp %b", outs(), O_JMP);
    end
    drive_nop();
  endtask

  task automatic test_mult();
    drive(5'b00000, 5'd0, 5'd0, OPC_MULT, 5'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (outs() !== O_MST) begin
      errors++; $display("FAIL mult_start got %b exp %b", outs(), O_MST);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (outs() !== O_MW) begin
        errors++; $display("FAIL mult_wait%0d got %b exp %b", i, outs(), O_MW);
      end
    end
    tick();
    checks++;
    if (outs() !== O_IDLE) begin
      errors++; $display("FAIL mult_exit got %b exp %b", outs(), O_IDLE);
    end
    drive_nop();
    tick();
    checks++;
    if (outs() !== O_IDLE) begin
      errors++; $display("FAIL mult_done got %b exp %b", outs(), O_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    drive(5'b00000, 5'd3, 5'd0, OPC_MULT, 5'd3, 1'b1, 1'b0);
    #1;
    checks++;
    if (outs() !== O_MST) begin
      errors++; $display("FAIL mult_over_ld got %b exp %b", outs(), O_MST);
    end
    tick();
    tick();
    tick();
    drive(5'b00000, 5'd3, 5'd0, OPC_LOAD_R, 5'd3, 1'b1, 1'b0);
    tick();
    checks++;
    if (outs() !== O_LDST) begin
      errors++; $display("FAIL ld_after_mult got %b exp %b", outs(), O_LDST);
    end
    tick();
    drive_nop();
    tick();
  endtask

  task automatic test_reset_mid_mult();
    drive(5'b00000, 5'd0, 5'd0, OPC_MULT, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== O_IDLE) begin
      errors++; $display("FAIL rst_async_outs got %b exp %b", outs(), O_IDLE);
    end
    drive_nop();
    tick();
    rst_n = 1'b1;
    drive(5'b00000, 5'd3, 5'd0, OPC_LOAD_R, 5'd3, 1'b1, 1'b0);
    #1;
    checks++;
    if (outs() !== O_LDST) begin
      errors++; $display("FAIL run_after_rst got %b exp %b", outs(), O_LDST);
    end
    tick();
    drive_nop();
    tick();
  endtask

  task automatic test_perf();
    logic [15:0] exp_cnt;
    do_reset();
    drive(5'b00000, 5'd3, 5'd0, OPC_LOAD_R, 5'd3, 1'b1, 1'b0);
    tick();
    drive_nop();
    tick();
    drive(5'b00000, 5'd0, 5'd0, OPC_MULT, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    drive_nop();
    tick();
    exp_cnt = PERF ? 16'd4 : 16'd0;
    checks++;
    if (hz_if.stall_cnt !== exp_cnt) begin
      errors++; $display("FAIL stall_cnt_ld_mult got %0d exp %0d", hz_if.stall_cnt, exp_cnt);
    end
`ifdef HAZARD_PERF_CNT_EN
    drive(OPC_BEQ, 5'd1, 5'd2, OPC_NOP, 5'd0, 1'b0, 1'b0);
    repeat (65540) @(posedge clk);
    #1;
    drive_nop();
    checks++;
    if (hz_if.stall_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL stall_cnt_saturate got %0h exp ffff", hz_if.stall_cnt);
    end
`endif
  endtask

  initial begin
    drive_nop();
    test_reset();
    test_load_use();
    test_no_rb_user();
    test_branch();
    test_mult();
    test_back_to_back();
    test_reset_mid_mult();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
